// File: rtl/baud_rate_generator.sv
// SPI serial-clock generator: divides PCLK by (sppr+1)<<(spr+1) into sclk with sample/drive strobes.
// Latency: sclk and all strobes are registered; first sclk toggle lands half a period after enable rises.
// Backpressure: none; dropping enable (ss high, stop, or wait with spiswai) parks sclk at cpol next cycle.
//
// Ports:
//   PCLK, PRESETn (async, active-high)  - clock and reset
//   spi_mode, spiswai, ss              - run/wait/stop mode, wait-mode clock stop, slave select (active-low)
//   sppr, spr                          - baud-rate preselection / selection
//   cpol, cpha                         - clock polarity / phase
//   sclk                               - serial clock
//   flag_low, flag_high                - receive-sample strobes (aligned with the sample edge)
//   flags_low, flags_high              - transmit-drive strobes (one cycle ahead of the drive edge)
//   baudratedivisor                    - combinational divisor, 2..2048

module baud_rate_generator (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [1:0]  spi_mode,
    input  logic        spiswai,
    input  logic [2:0]  sppr,
    input  logic [2:0]  spr,
    input  logic        cpol,
    input  logic        cpha,
    input  logic        ss,
    output logic        sclk,
    output logic        flag_low,
    output logic        flag_high,
    output logic        flags_low,
    output logic        flags_high,
    output logic [11:0] baudratedivisor
);

    logic [3:0]  presel;
    logic [3:0]  shamt;
    logic [11:0] half;
    logic [11:0] half_m1;
    logic [11:0] half_m2;
    logic [11:0] count;
    logic        enable;
    logic        sample_rise;
    logic        at_toggle;
    logic        tx_pre;

    // (sppr+1) is at most 8 and the shift at most 8, so the product never exceeds 2048.
    assign presel          = {1'b0, sppr} + 4'd1;
    assign shamt           = {1'b0, spr} + 4'd1;
    assign baudratedivisor = {8'd0, presel} << shamt;

    assign half    = {1'b0, baudratedivisor[11:1]};
    assign half_m1 = half - 12'd1;
    assign half_m2 = half - 12'd2;

    assign enable = !ss && ((spi_mode == 2'b00) || ((spi_mode == 2'b01) && !spiswai));

    // Modes 0 and 3 sample on the rising edge; the drive edge is always the other one.
    assign sample_rise = (cpol == cpha);

    // ">=" rather than "==" so a divisor shrinking mid-run cannot strand count above the
    // terminal value and force a full 12-bit wrap.
    assign at_toggle = (count >= half_m1);

    // With half==1 sclk toggles every cycle, so there is no "count==half-2" slot to look
    // ahead from; every cycle is then one cycle before a drive edge.
    assign tx_pre = (half == 12'd1) ? at_toggle : (count == half_m2);

    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            count      <= 12'd0;
            sclk       <= 1'b0;
            flag_low   <= 1'b0;
            flag_high  <= 1'b0;
            flags_low  <= 1'b0;
            flags_high <= 1'b0;
        end else if (!enable) begin
            count      <= 12'd0;
            sclk       <= cpol;
            flag_low   <= 1'b0;
            flag_high  <= 1'b0;
            flags_low  <= 1'b0;
            flags_high <= 1'b0;
        end else begin
            if (at_toggle) begin
                count <= 12'd0;
                sclk  <= ~sclk;
            end else begin
                count <= count + 12'd1;
            end
            flag_low   <= at_toggle && !sclk && sample_rise;
            flag_high  <= at_toggle &&  sclk && !sample_rise;
            flags_low  <= tx_pre    && !sclk && !sample_rise;
            flags_high <= tx_pre    &&  sclk && sample_rise;
        end
    end

endmodule

// File: tb/tb_baud_rate_generator.sv
module tb_baud_rate_generator;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [1:0]  spi_mode;
    logic        spiswai;
    logic [2:0]  sppr;
    logic [2:0]  spr;
    logic        cpol;
    logic        cpha;
    logic        ss;
    logic        sclk;
    logic        flag_low;
    logic        flag_high;
    logic        flags_low;
    logic        flags_high;
    logic [11:0] baudratedivisor;

    baud_rate_generator dut (
        .PCLK            (PCLK),
        .PRESETn         (PRESETn),
        .spi_mode        (spi_mode),
        .spiswai         (spiswai),
        .sppr            (sppr),
        .spr             (spr),
        .cpol            (cpol),
        .cpha            (cpha),
        .ss              (ss),
        .sclk            (sclk),
        .flag_low        (flag_low),
        .flag_high       (flag_high),
        .flags_low       (flags_low),
        .flags_high      (flags_high),
        .baudratedivisor (baudratedivisor)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic        sclk;
        logic        fl;
        logic        fh;
        logic        fsl;
        logic        fsh;
        logic [11:0] div;
    } obs_t;

    obs_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: elapsed enabled cycles since the clock left idle, plus the idle level.
    int   n_en  = 0;
    logic base  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Predict the outputs after the next rising edge from the current inputs.
    task automatic predict();
        obs_t e;
        int   div, half, c, m;
        logic s, en, rise;
        en   = !ss && (spi_mode == 2'b00 || (spi_mode == 2'b01 && !spiswai));
        div  = (int'(sppr) + 1) * (1 << (int'(spr) + 1));
        half = div / 2;
        rise = (cpol == cpha);
        e    = '0;
        e.div = 12'(div);
        if (!en) begin
            base  = cpol;
            n_en  = 0;
            e.sclk = cpol;
        end else begin
            m = n_en;
            c = m % half;
            s = base ^ 1'((m / half) & 1);
            e.fl  = (c == half - 1) && !s && rise;
            e.fh  = (c == half - 1) &&  s && !rise;
            e.fsl = ((half == 1) || (c == half - 2)) && !s && !rise;
            e.fsh = ((half == 1) || (c == half - 2)) &&  s && rise;
            n_en++;
            e.sclk = base ^ 1'((n_en / half) & 1);
        end
        q.push_back(e);
    endtask

    task automatic cyc(input int k);
        for (int i = 0; i < k; i++) begin
            predict();
            @(negedge PCLK);
        end
    endtask

    // Monitor: every cycle the DUT presents a fresh registered output set.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge PCLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {sclk, flag_low, flag_high, flags_low, flags_high, baudratedivisor};
                check("cycle_outputs", 32'(a), 32'(e));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        PRESETn  = 1'b1;
        spi_mode = 2'b00;
        spiswai  = 1'b0;
        sppr     = 3'd0;
        spr      = 3'd1;
        cpol     = 1'b0;
        cpha     = 1'b0;
        ss       = 1'b0;

        // Reset state and divisor decoding while held in reset.
        @(negedge PCLK);
        @(negedge PCLK);
        check("reset_sclk", 32'(sclk), 32'd0);
        check("reset_flags", 32'({flag_low, flag_high, flags_low, flags_high}), 32'd0);
        check("div_0_1", 32'(baudratedivisor), 32'd4);
        sppr = 3'd7; spr = 3'd7; #1;
        check("div_7_7", 32'(baudratedivisor), 32'd2048);
        sppr = 3'd0; spr = 3'd0; #1;
        check("div_0_0", 32'(baudratedivisor), 32'd2);

        // Release with ss high and cpol=1: sclk should go idle-high after one cycle.
        @(negedge PCLK);
        PRESETn = 1'b0;
        ss      = 1'b1;
        cpol    = 1'b1;
        sppr    = 3'd0;
        spr     = 3'd1;
        n_en    = 0;
        base    = 1'b0;
        cyc(3);

        // Divisor 4 in all four clock modes, ss low for 20 cycles.
        for (int mode = 0; mode < 4; mode++) begin
            ss   = 1'b1;
            cpol = 1'(mode >> 1);
            cpha = 1'(mode & 1);
            cyc(2);
            ss = 1'b0;
            cyc(20);
            ss = 1'b1;
            cyc(3);
        end

        // Largest and smallest divisors.
        cpol = 1'b0; cpha = 1'b0; sppr = 3'd7; spr = 3'd7;
        cyc(2);
        ss = 1'b0;
        cyc(2100);
        ss = 1'b1;
        sppr = 3'd0; spr = 3'd0; cpha = 1'b1;
        cyc(2);
        ss = 1'b0;
        cyc(12);
        ss = 1'b1;
        cyc(2);

        // Wait mode with and without spiswai, then stop mode.
        sppr = 3'd0; spr = 3'd1; cpol = 1'b1; cpha = 1'b0;
        cyc(2);
        ss = 1'b0; spi_mode = 2'b01; spiswai = 1'b1;
        cyc(8);
        spiswai = 1'b0;
        cyc(12);
        spi_mode = 2'b10;
        cyc(6);
        spi_mode = 2'b11;
        cyc(4);
        spi_mode = 2'b00;
        ss = 1'b1;
        cyc(2);

        // Randomized segments; divisor and clock mode only change while ss is high.
        for (int seg = 0; seg < 30; seg++) begin
            ss       = 1'b1;
            sppr     = 3'($urandom_range(0, 7));
            spr      = 3'($urandom_range(0, 3));
            cpol     = 1'($urandom_range(0, 1));
            cpha     = 1'($urandom_range(0, 1));
            spi_mode = 2'b00;
            spiswai  = 1'($urandom_range(0, 1));
            cyc(2);
            ss = 1'b0;
            if ($urandom_range(0, 2) == 0) spi_mode = 2'b01;
            cyc($urandom_range(5, 150));
            if ($urandom_range(0, 3) == 0) begin
                spi_mode = 2'b01;
                spiswai  = 1'b1;
                cyc(3);
                spi_mode = 2'b00;
                cyc($urandom_range(5, 40));
            end
            ss = 1'b1;
            cyc(2);
        end

        @(posedge PCLK);
        #2;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/baud_rate_generator.md
Name: baud_rate_generator

Overview:
SPI serial-clock generator for the APB SPI master core. Divides PCLK by a programmable baud-rate divisor to produce sclk with the selected polarity. Also produces single-cycle receive-sample strobes (flag_low/flag_high) and transmit-drive strobes (flags_low/flags_high) for the shift-register block. Sits between the SPI control/status registers and the shifter.

Parameters:
none. Divisor width is fixed at 12 bits.

Ports:
PCLK  input  1  system clock; all state on rising edge
PRESETn  input  1  asynchronous reset, active-high: 1 = reset
spi_mode  input  2  00 run, 01 wait, 10/11 stop
spiswai  input  1  1 = stop SPI clock while in wait mode
sppr  input  3  baud-rate preselection
spr  input  3  baud-rate selection
cpol  input  1  clock polarity; idle level of sclk
cpha  input  1  clock phase
ss  input  1  slave select, active-low; 0 = transfer in progress
sclk  output  1  SPI serial clock (registered)
flag_low  output  1  receive strobe while sclk low
flag_high  output  1  receive strobe while sclk high
flags_low  output  1  transmit strobe while sclk low
flags_high  output  1  transmit strobe while sclk high
baudratedivisor  output  12  (sppr+1) * 2^(spr+1), combinational

Behaviour:
- Divisor: baudratedivisor = (sppr+1) << (spr+1). Range 2..2048; it always fits in 12 bits and is never zero. half = baudratedivisor/2.
- enable = !ss && (spi_mode==00 || (spi_mode==01 && !spiswai)).
- Reset (PRESETn=1, asynchronous): count=0, sclk=0, all four flags=0.
- Disabled (enable=0): each cycle count<=0, sclk<=cpol, flags<=0. sclk therefore reaches the idle level one cycle after reset release or after a disable.
- Enabled:
  - 12-bit count increments each PCLK.
  - When count >= half-1: count<=0 and sclk<=~sclk.
  - The >= comparison ensures a divisor change mid-run never causes wrap-around.
  - sclk period is baudratedivisor PCLK cycles, with a 50% duty cycle.
  - First toggle occurs half cycles after enable rises.
- Sample edge: rising if cpol==cpha, falling otherwise. Drive edge is the opposite edge.
- Receive strobes (registered, 1 cycle wide, asserted in the cycle where the toggle is registered, i.e. aligned with the edge):
  - flag_low = enable && count>=half-1 && sclk==0 && sample edge rising.
  - flag_high = enable && count>=half-1 && sclk==1 && sample edge falling.
- Transmit strobes (one cycle before the drive edge):
  - Precondition: enable && count==half-2 (or count>=half-1 when half==1).
  - flags_low = precondition && sclk==0 && drive edge rising.
  - flags_high = precondition && sclk==1 && drive edge falling.
- Exclusivity: at most one of flag_low/flag_high and at most one of flags_low/flags_high is high in any cycle.
- ss rising mid-transfer: next cycle count=0, sclk=cpol, flags=0. No partial pulse is generated.
- Stop mode, or wait mode with spiswai=1: same as ss high.
- cpol/cpha changes are honoured immediately; software changes them only while ss=1.

Test Plan:
- sppr=0, spr=1 -> baudratedivisor=4. sppr=7, spr=7 -> 2048. sppr=0, spr=0 -> 2.
- Reset asserted -> sclk=0, all flags 0. Release with ss=1, cpol=1 -> sclk=1 after one cycle, flags stay 0.
- divisor 4, cpol=0, cpha=0, ss 1->0 -> sclk toggles every 2 PCLK (period 4). flag_low pulses once per period aligned with the rising edge. flags_high pulses one cycle before each falling edge. flag_high and flags_low stay 0.
- Same divisor, modes (0,1), (1,0), (1,1):
  - (0,1) -> flag_high and flags_low active.
  - (1,0) -> sclk idles 1, flag_high and flags_low active.
  - (1,1) -> flag_low and flags_high active.
- ss returned to 1 after 20 PCLK -> sclk returns to cpol next cycle, count cleared, no flag pulses.
- spi_mode=01 with spiswai=1 -> sclk held at cpol. spiswai=0 -> toggling. spi_mode=10 -> held at cpol.
